pi_math_seq: RTL and testbench



---
 rtl/pi_math_seq_if.sv | 29 ++
 rtl/pi_math_seq.sv | 131 +++++++++++++
 tb/tb_pi_math_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pi_math_seq_if.sv
// pi_math_seq_if: select/control bus between the PI sequencer (master) and
// the combinational PI ALU (slave).
//   src0sel/src1sel        operand selects
//   multiply..saturate     op controls
//   accum..icomp           working registers fed back as ALU operands
//   pterm/iterm            gain constants
//   a2d_res/fwd            sensor sample and setpoint, forwarded to the ALU
//   dst                    ALU result (signed)
interface pi_math_seq_if;
  logic [2:0]  src0sel, src1sel;
  logic        multiply, sub, mult2, mult4, saturate;
  logic [15:0] accum, pcomp;
  logic [11:0] error, intgrl, icomp;
  logic [13:0] pterm;
  logic [11:0] iterm;
  logic [11:0] a2d_res, fwd;
  logic [15:0] dst;

  modport master (
    output src0sel, src1sel, multiply, sub, mult2, mult4, saturate,
           accum, pcomp, error, intgrl, icomp, pterm, iterm, a2d_res, fwd,
    input  dst
  );
  modport slave (
    input  src0sel, src1sel, multiply, sub, mult2, mult4, saturate,
           accum, pcomp, error, intgrl, icomp, pterm, iterm, a2d_res, fwd,
    output dst
  );
endinterface

// File: rtl/pi_math_seq.sv
// pi_math_seq: six-step microcoded PI sequencer driving the PI ALU.
//   clk, rst     clock, synchronous active-high reset
//   go_i         start request, sampled only in IDLE
//   a2d_res_i    sensor sample (held while busy)
//   fwd_i        forward-speed setpoint (held while busy)
//   alu          master side of the ALU select/control bus
//   result_o     signed 12-bit drive value
//   busy_o       high outside IDLE
//   done_o       one-cycle pulse after result_o updates
module pi_math_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        go_i,
  input  logic [11:0] a2d_res_i,
  input  logic [11:0] fwd_i,
  pi_math_seq_if.master alu,
  output logic [11:0] result_o,
  output logic        busy_o,
  output logic        done_o
);
  localparam logic [13:0] PTERM = 14'h3680;
  localparam logic [11:0] ITERM = 12'h0500;

  localparam logic [2:0] S0_A2D = 3'd0, S0_INTGRL = 3'd1, S0_ICOMP = 3'd2,
                         S0_PCOMP = 3'd3, S0_PTERM = 3'd4;
  localparam logic [2:0] S1_ACCUM = 3'd0, S1_ITERM = 3'd1, S1_ERR = 3'd2,
                         S1_ERR_TOP = 3'd3, S1_FWD = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_INT, S_ICMP, S_PCMP, S_ACC1, S_ACC2
  } state_e;

  typedef struct packed {
    logic [2:0] src0sel;
    logic [2:0] src1sel;
    logic       multiply;
    logic       sub;
    logic       saturate;
  } ctrl_t;

  // Microcode ROM: ALU setup for each step.
  function automatic ctrl_t decode(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_ERR:  begin c.src0sel = S0_A2D;    c.src1sel = S1_FWD;     c.sub = 1'b1; c.saturate = 1'b1; end
      S_INT:  begin c.src0sel = S0_INTGRL; c.src1sel = S1_ERR_TOP; c.saturate = 1'b1; end
      S_ICMP: begin c.src0sel = S0_INTGRL; c.src1sel = S1_ITERM;   c.multiply = 1'b1; end
      S_PCMP: begin c.src0sel = S0_PTERM;  c.src1sel = S1_ERR;     c.multiply = 1'b1; end
      S_ACC1: begin c.src0sel = S0_PCOMP;  c.src1sel = S1_FWD;     c.sub = 1'b1; end
      S_ACC2: begin c.src0sel = S0_ICOMP;  c.src1sel = S1_ACCUM;   c.saturate = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e      state_q, state_d;
  ctrl_t       ctrl_q;
  logic [11:0] error_q, intgrl_q, icomp_q, result_q;
  logic [15:0] pcomp_q, accum_q;
  logic [1:0]  int_dec_q;
  logic        done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (go_i) state_d = S_ERR;
      S_ERR:  state_d = S_INT;
      S_INT:  state_d = S_ICMP;
      S_ICMP: state_d = S_PCMP;
      S_PCMP: state_d = S_ACC1;
      S_ACC1: state_d = S_ACC2;
      S_ACC2: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Controls are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      error_q   <= '0;
      intgrl_q  <= '0;
      icomp_q   <= '0;
      pcomp_q   <= '0;
      accum_q   <= '0;
      result_q  <= '0;
      int_dec_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
      done_q  <= (state_q == S_ACC2);
      case (state_q)
        S_ERR:  error_q <= alu.dst[11:0];
        // Integrator only accumulates on every 4th computation.
        S_INT:  if (int_dec_q == 2'b11) intgrl_q <= alu.dst[11:0];
        S_ICMP: icomp_q <= alu.dst[11:0];
        S_PCMP: pcomp_q <= alu.dst;
        S_ACC1: accum_q <= alu.dst;
        S_ACC2: begin
          result_q  <= alu.dst[11:0];
          int_dec_q <= int_dec_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign alu.src0sel  = ctrl_q.src0sel;
  assign alu.src1sel  = ctrl_q.src1sel;
  assign alu.multiply = ctrl_q.multiply;
  assign alu.sub      = ctrl_q.sub;
  assign alu.saturate = ctrl_q.saturate;
  assign alu.mult2    = 1'b0;
  assign alu.mult4    = 1'b0;
  assign alu.accum    = accum_q;
  assign alu.pcomp    = pcomp_q;
  assign alu.error    = error_q;
  assign alu.intgrl   = intgrl_q;
  assign alu.icomp    = icomp_q;
  assign alu.pterm    = PTERM;
  assign alu.iterm    = ITERM;
  assign alu.a2d_res  = a2d_res_i;
  assign alu.fwd      = fwd_i;

  assign result_o = result_q;
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
endmodule

// File: tb/tb_pi_math_seq.sv
// tb_pi_math_seq: directed bench for pi_math_seq with a behavioural PI ALU
// on the slave side of the bus.
module tb_pi_math_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go_i = 1'b0;
  logic [11:0] a2d_res_i = '0;
  logic [11:0] fwd_i = '0;
  logic [11:0] result_o;
  logic        busy_o, done_o;
  int          nchk = 0;
  int          nerr = 0;

  pi_math_seq_if bus();

  pi_math_seq dut (
    .clk(clk), .rst(rst), .go_i(go_i), .a2d_res_i(a2d_res_i), .fwd_i(fwd_i),
    .alu(bus), .result_o(result_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // PI ALU model: dst = src1 +/- src0 (optionally clamped to 12-bit signed),
  // or (src0*src1) >> 12 when multiplying.
  logic signed [15:0] s0, s1;
  logic signed [31:0] prod;
  logic signed [16:0] sum;
  always_comb begin
    case (bus.src0sel)
      3'd0: s0 = {4'b0, bus.a2d_res};
      3'd1: s0 = {{4{bus.intgrl[11]}}, bus.intgrl};
      3'd2: s0 = {{4{bus.icomp[11]}}, bus.icomp};
      3'd3: s0 = bus.pcomp;
      3'd4: s0 = {2'b0, bus.pterm};
      default: s0 = '0;
    endcase
    case (bus.src1sel)
      3'd0: s1 = bus.accum;
      3'd1: s1 = {4'b0, bus.iterm};
      3'd2: s1 = {{4{bus.error[11]}}, bus.error};
      3'd3: s1 = {{8{bus.error[11]}}, bus.error[11:4]};
      3'd4: s1 = {4'b0, bus.fwd};
      default: s1 = '0;
    endcase
    prod = s0 * s1;
    sum  = bus.sub ? ($signed({s1[15], s1}) - $signed({s0[15], s0}))
                   : ($signed({s1[15], s1}) + $signed({s0[15], s0}));
    if (bus.multiply)                           bus.dst = prod[27:12];
    else if (bus.saturate && sum > 17'sd2047)   bus.dst = 16'h07FF;
    else if (bus.saturate && sum < -17'sd2048)  bus.dst = 16'hF800;
    else                                        bus.dst = sum[15:0];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Packed view of the decoded controls: {src0,src1,mul,sub,m2,m4,sat,busy}.
  function automatic logic [15:0] ctl();
    return {4'b0, bus.src0sel, bus.src1sel, bus.multiply, bus.sub,
            bus.mult2, bus.mult4, bus.saturate, busy_o};
  endfunction

  // Issue one go and return at the negedge of the cycle after the go edge.
  task automatic start();
    @(negedge clk); go_i = 1'b1;
    @(negedge clk); go_i = 1'b0;
  endtask

  // One full computation: checks ERR decode, done latency and done width.
  task automatic run(input string tag);
    int lat;
    start();
    chk({tag, " err_decode"}, ctl(), 16'b0000_000_100_0_1_0_0_1_1);
    lat = 1;
    while (!done_o && lat < 30) begin @(negedge clk); lat++; end
    chk({tag, " done_latency"}, 16'(lat), 16'd7);
    @(negedge clk);
    chk({tag, " done_pulse_width"}, {15'b0, done_o}, 16'd0);
  endtask

  initial begin
    int ndone, lat;

    // reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst error",  {4'b0, bus.error},  16'h0);
    chk("rst intgrl", {4'b0, bus.intgrl}, 16'h0);
    chk("rst icomp",  {4'b0, bus.icomp},  16'h0);
    chk("rst pcomp",  bus.pcomp,          16'h0);
    chk("rst accum",  bus.accum,          16'h0);
    chk("rst result", {4'b0, result_o},   16'h0);
    chk("rst done",   {15'b0, done_o},    16'h0);
    chk("rst ctl",    ctl(),              16'h0);
    rst = 1'b0;

    // basic pass
    fwd_i = 12'h100; a2d_res_i = 12'h080;
    run("basic");
    chk("basic error",  {4'b0, bus.error},  16'h0080);
    chk("basic intgrl", {4'b0, bus.intgrl}, 16'h0000);
    chk("basic icomp",  {4'b0, bus.icomp},  16'h0000);
    chk("basic pcomp",  bus.pcomp,          16'h01B4);
    chk("basic accum",  bus.accum,          16'hFF4C);
    chk("basic result", {4'b0, result_o},   16'h0F4C);
    chk("basic idle",   {15'b0, busy_o},    16'h0);

    // integrator cadence from a clean int_dec
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      run($sformatf("cad%0d", i));
      chk($sformatf("cad%0d intgrl", i), {4'b0, bus.intgrl}, (i == 4) ? 16'h0008 : 16'h0000);
    end
    chk("cad4 icomp",  {4'b0, bus.icomp}, 16'h0002);
    chk("cad4 result", {4'b0, result_o},  16'h0F4E);
    run("cad5");
    chk("cad5 intgrl_hold", {4'b0, bus.intgrl}, 16'h0008);
    chk("cad5 result",      {4'b0, result_o},   16'h0F4E);

    // go held high restarts right after done
    @(negedge clk); go_i = 1'b1;
    lat = 0;
    while (!done_o && lat < 30) begin @(negedge clk); lat++; end
    chk("held done_latency", 16'(lat), 16'd7);
    @(negedge clk);
    chk("held restart_busy", {15'b0, busy_o}, 16'd1);
    go_i = 1'b0;
    lat = 0;
    while (!done_o && lat < 30) begin @(negedge clk); lat++; end
    chk("held second_done", {15'b0, done_o}, 16'd1);
    @(negedge clk);

    // error saturation
    fwd_i = 12'hFFF; a2d_res_i = 12'h000;
    run("sat");
    chk("sat error", {4'b0, bus.error}, 16'h07FF);

    // go during ACC1 is ignored
    fwd_i = 12'h100; a2d_res_i = 12'h080;
    start();
    repeat (4) @(negedge clk);
    chk("acc1 decode", ctl(), 16'b0000_011_100_0_1_0_0_0_1);
    go_i = 1'b1; @(negedge clk); go_i = 1'b0;
    ndone = 0;
    repeat (12) begin @(negedge clk); if (done_o) ndone++; end
    chk("acc1go done_count", 16'(ndone), 16'd1);
    chk("acc1go idle", {15'b0, busy_o}, 16'd0);

    // reset in PCMP
    start();
    repeat (3) @(negedge clk);
    chk("pcmp decode", ctl(), 16'b0000_100_010_1_0_0_0_0_1);
    rst = 1'b1; @(negedge clk);
    chk("pcmprst busy",   {15'b0, busy_o},  16'd0);
    chk("pcmprst pcomp",  bus.pcomp,        16'h0);
    chk("pcmprst accum",  bus.accum,        16'h0);
    chk("pcmprst result", {4'b0, result_o}, 16'h0);
    chk("pcmprst error",  {4'b0, bus.error}, 16'h0);
    rst = 1'b0;
    ndone = 0;
    repeat (10) begin @(negedge clk); if (done_o) ndone++; end
    chk("pcmprst no_done", 16'(ndone), 16'd0);
    run("after_rst");
    chk("after_rst result", {4'b0, result_o}, 16'h0F4C);
    chk("after_rst pcomp",  bus.pcomp,        16'h01B4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
